// File: rtl/twos_complement_serial_if.sv
// Operand/result bundle for the bit-serial two's-complement unit.
// valid/ready-style contract: start is taken only while busy=0; valid pulses one cycle when b/ovf change.
interface twos_complement_serial_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             valid;
    logic             busy;
    logic             ovf;
    logic [1:0]       state;

    modport master (
        output start, mode, a,
        input  b, valid, busy, ovf, state
    );

    modport slave (
        input  start, mode, a,
        output b, valid, busy, ovf, state
    );
endinterface

// File: rtl/twos_complement_serial.sv
// Bit-serial two's-complement unit: NEG, ABS, ONES and PASS on a WIDTH-bit operand, LSB first,
// one bit per clock, with overflow flagged when the most-negative value is negated.
module twos_complement_serial #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    twos_complement_serial_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] MODE_NEG  = 2'b00;
    localparam logic [1:0] MODE_ABS  = 2'b01;
    localparam logic [1:0] MODE_ONES = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] rsr;
    logic [1:0]       mode_q;
    logic             neg_en;
    logic             seen_one;
    logic             zlow;
    logic             x_msb;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] b_q;
    logic             ovf_q;
    logic             valid_q;
    logic             busy_q;

    logic             x;
    logic             y;

    // Serial negation: copy bits up to and including the first 1, invert every bit after it.
    always_comb begin
        x = sr[0];
        y = x;
        case (mode_q)
            MODE_NEG, MODE_ABS: y = (neg_en && seen_one) ? ~x : x;
            MODE_ONES:          y = ~x;
            default:            y = x;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sr       <= '0;
            rsr      <= '0;
            mode_q   <= '0;
            neg_en   <= 1'b0;
            seen_one <= 1'b0;
            zlow     <= 1'b0;
            x_msb    <= 1'b0;
            cnt      <= '0;
            b_q      <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sr       <= bus.a;
                        mode_q   <= bus.mode;
                        neg_en   <= (bus.mode == MODE_NEG) ? 1'b1 :
                                    (bus.mode == MODE_ABS) ? bus.a[WIDTH-1] : 1'b0;
                        seen_one <= 1'b0;
                        cnt      <= '0;
                        zlow     <= 1'b1;
                        x_msb    <= 1'b0;
                        busy_q   <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr       <= {1'b0, sr[WIDTH-1:1]};
                    rsr      <= {y, rsr[WIDTH-1:1]};
                    seen_one <= seen_one | x;
                    if (cnt == CW'(WIDTH - 1)) begin
                        x_msb <= x;
                        state <= DONE;
                    end else begin
                        // zlow covers only bits below the sign bit
                        zlow <= zlow & ~x;
                        cnt  <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    b_q     <= rsr;
                    ovf_q   <= neg_en & x_msb & zlow;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.b     = b_q;
    assign bus.ovf   = ovf_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.state = state;
endmodule
